// File: rtl/counter_pkg.sv
// Shared encodings for the counter_modes block and its scoreboard.
// No logic: constants and the FSM state type only.
package counter_pkg;

    localparam logic [1:0] MODO_UP  = 2'b00;
    localparam logic [1:0] MODO_DN1 = 2'b01;
    localparam logic [1:0] MODO_DN3 = 2'b10;
    localparam logic [1:0] MODO_LD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_LOAD = 2'b10
    } state_t;

endpackage

// File: rtl/counter_modes_next.sv
// Next-state function of the counter: (q, modo, d) -> (next_q, next_rco, next_load).
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
// COUNTER_SAT_EN selects saturating instead of wrapping arithmetic.
module counter_modes_next
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DOWN_STEP = 3
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] next_q,
    output logic             next_rco,
    output logic             next_load
);

    localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP = (WIDTH+1)'(DOWN_STEP);

    logic [WIDTH:0] sum;

    always_comb begin
        sum       = '0;
        next_q    = q;
        next_rco  = 1'b0;
        next_load = 1'b0;
        case (modo)
            MODO_UP:  sum = {1'b0, q} + ONE;
            MODO_DN1: sum = {1'b0, q} - ONE;
            MODO_DN3: sum = {1'b0, q} - STEP;
            default:  sum = '0;
        endcase

        if (modo == MODO_LD) begin
            next_q    = d;
            next_load = 1'b1;
        end else begin
            // Extra MSB is carry for up-counting and borrow for down-counting.
            next_rco = sum[WIDTH];
`ifdef COUNTER_SAT_EN
            if (sum[WIDTH])
                next_q = (modo == MODO_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            else
                next_q = sum[WIDTH-1:0];
`else
            next_q = sum[WIDTH-1:0];
`endif
        end
    end

endmodule

// File: rtl/counter_modes.sv
// Multi-mode up/down/load counter; RCO and LOAD are single-cycle pulses.
// Latency: 1 cycle from sampled request to registered Q/RCO/LOAD.
// Backpressure: none; ENABLE=0 holds Q. Optional macro COUNTER_SAT_EN (saturate).
module counter_modes
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DOWN_STEP = 3
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             LOAD
);

    state_t           state;
    logic [WIDTH-1:0] next_q;
    logic             next_rco;
    logic             next_load;

    counter_modes_next #(
        .WIDTH     (WIDTH),
        .DOWN_STEP (DOWN_STEP)
    ) u_next (
        .q         (Q),
        .modo      (MODO),
        .d         (D),
        .next_q    (next_q),
        .next_rco  (next_rco),
        .next_load (next_load)
    );

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
            Q     <= '0;
            RCO   <= 1'b0;
            LOAD  <= 1'b0;
        end else if (ENABLE) begin
            Q    <= next_q;
            RCO  <= next_rco;
            LOAD <= next_load;
            case (state)
                ST_IDLE, ST_RUN, ST_LOAD:
                    state <= (MODO == MODO_LD) ? ST_LOAD : ST_RUN;
                default:
                    state <= ST_IDLE;
            endcase
        end else begin
            // Idle cycle: hold the count, drop both pulses.
            state <= ST_IDLE;
            RCO   <= 1'b0;
            LOAD  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_modes.sv
// Directed plus randomised checks of counter_modes against an integer reference model.
module tb_counter_modes;
    import counter_pkg::*;

    localparam int WIDTH     = 4;
    localparam int DOWN_STEP = 3;
    localparam int MODV      = 1 << WIDTH;
    localparam int MAXV      = MODV - 1;
`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk;
    logic             RESET;
    logic             ENABLE;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             RCO;
    logic             LOAD;

    int checks = 0;
    int errors = 0;
    int mq     = 0;
    int m_rco  = 0;
    int m_load = 0;

    counter_modes #(
        .WIDTH     (WIDTH),
        .DOWN_STEP (DOWN_STEP)
    ) dut (
        .clk    (clk),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .MODO   (MODO),
        .D      (D),
        .Q      (Q),
        .RCO    (RCO),
        .LOAD   (LOAD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int eq, input int ercO, input int eld);
        chk({tag, ".q"},    32'(Q),    32'(eq));
        chk({tag, ".rco"},  32'(RCO),  32'(ercO));
        chk({tag, ".load"}, 32'(LOAD), 32'(eld));
    endtask

    // Reference: plain integer arithmetic on the count value.
    task automatic model_step(input bit en, input logic [1:0] m, input int dv);
        m_rco  = 0;
        m_load = 0;
        if (en) begin
            case (m)
                MODO_UP: begin
                    m_rco = (mq == MAXV) ? 1 : 0;
                    mq    = (mq == MAXV) ? (SAT ? MAXV : 0) : mq + 1;
                end
                MODO_DN1: begin
                    m_rco = (mq == 0) ? 1 : 0;
                    mq    = (mq == 0) ? (SAT ? 0 : MAXV) : mq - 1;
                end
                MODO_DN3: begin
                    m_rco = (mq < DOWN_STEP) ? 1 : 0;
                    mq    = (mq < DOWN_STEP) ? (SAT ? 0 : mq - DOWN_STEP + MODV) : mq - DOWN_STEP;
                end
                default: begin
                    mq     = dv;
                    m_load = 1;
                end
            endcase
        end
    endtask

    task automatic do_req(input string tag, input bit en, input logic [1:0] m, input int dv);
        ENABLE = en;
        MODO   = m;
        D      = WIDTH'(dv);
        model_step(en, m, dv);
        @(posedge clk);
        #1;
        chk_out(tag, mq, m_rco, m_load);
        chk({tag, ".excl"}, 32'(RCO & LOAD), 32'd0);
    endtask

    initial begin
        RESET  = 1'b0;
        ENABLE = 1'b0;
        MODO   = MODO_UP;
        D      = '0;
        #2;
        chk_out("reset_init", 0, 0, 0);
        #10 RESET = 1'b1;

        // Asynchronous reset mid-count with Q=7.
        do_req("ld6", 1'b1, MODO_LD, 6);
        do_req("up7", 1'b1, MODO_UP, 0);
        chk("q_is_7", 32'(Q), 32'd7);
        #2 RESET = 1'b0;
        mq = 0;
        #1;
        chk_out("async_rst", 0, 0, 0);
        #3 RESET = 1'b1;
        do_req("first_up", 1'b1, MODO_UP, 0);
        chk("first_up_q1", 32'(Q), 32'd1);

        // Up wrap.
        do_req("ld14", 1'b1, MODO_LD, 14);
        do_req("upw0", 1'b1, MODO_UP, 0);
        chk_out("upw0_c", 15, 0, 0);
        do_req("upw1", 1'b1, MODO_UP, 0);
        chk_out("upw1_c", SAT ? 15 : 0, 1, 0);
        do_req("upw2", 1'b1, MODO_UP, 0);
        chk_out("upw2_c", SAT ? 15 : 1, SAT ? 1 : 0, 0);

        // Down-by-1 wrap.
        do_req("ld1", 1'b1, MODO_LD, 1);
        do_req("dn1a", 1'b1, MODO_DN1, 0);
        chk_out("dn1a_c", 0, 0, 0);
        do_req("dn1b", 1'b1, MODO_DN1, 0);
        chk_out("dn1b_c", SAT ? 0 : 15, 1, 0);

        // Down-by-3 borrow.
        do_req("ld4", 1'b1, MODO_LD, 4);
        do_req("dn3a", 1'b1, MODO_DN3, 0);
        chk_out("dn3a_c", 1, 0, 0);
        do_req("dn3b", 1'b1, MODO_DN3, 0);
        chk_out("dn3b_c", SAT ? 0 : 14, 1, 0);

        // Load then hold with inputs toggling.
        do_req("ld9", 1'b1, MODO_LD, 9);
        chk_out("ld9_c", 9, 0, 1);
        for (int i = 0; i < 5; i++) begin
            do_req("hold", 1'b0, 2'(i), (i * 5 + 3) % MODV);
            chk_out("hold_c", 9, 0, 0);
        end

        // Randomised requests.
        for (int i = 0; i < 100; i++) begin
            do_req("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, MAXV)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
